// File: rtl/da_lut_loader.sv
// Distributed-arithmetic LUT loader: collects 8 signed taps per bank and writes
// all 256 partial sums of each bank to the coefficient SRAM, walking addresses in Gray order.
module da_lut_loader #(
  parameter int COEF_W = 16,
  parameter int NBANK  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_valid,
  output logic              coef_ready,
  output logic [19:0]       CIN,
  output logic [10:0]       CADDR,
  output logic              CLOAD,
  output logic              busy,
  output logic              done
);

  localparam int         SUM_W     = 20;
  localparam logic [2:0] LAST_BANK = 3'(NBANK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_GEN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        bank_q, bank_d;
  logic [2:0]        tap_cnt_q, tap_cnt_d;
  logic [7:0]        step_q, step_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [COEF_W-1:0] taps_q [8];
  logic              take;

  logic [7:0]        step_nxt;
  logic [7:0]        gray_q;
  logic [7:0]        gray_nxt;
  logic [2:0]        flip_bit;
  logic [COEF_W-1:0] flip_tap;
  logic [SUM_W-1:0]  flip_ext;

  // Consecutive Gray codes differ in the bit given by the lowest set bit of k+1,
  // so each new partial sum is the previous one plus or minus a single tap.
  assign step_nxt = step_q + 8'd1;
  assign gray_q   = step_q ^ (step_q >> 1);
  assign gray_nxt = step_nxt ^ (step_nxt >> 1);

  always_comb begin
    flip_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (step_nxt[i]) flip_bit = 3'(i);
    end
  end

  assign flip_tap = taps_q[flip_bit];
  assign flip_ext = {{(SUM_W - COEF_W){flip_tap[COEF_W-1]}}, flip_tap};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      bank_q    <= '0;
      tap_cnt_q <= '0;
      step_q    <= '0;
      sum_q     <= '0;
      // NOTE: the tap buffer is eight flops, not an SRAM, so clearing it on reset
      // is cheap; a real memory array would normally be left unreset.
      for (int i = 0; i < 8; i++) taps_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      bank_q    <= bank_d;
      tap_cnt_q <= tap_cnt_d;
      step_q    <= step_d;
      sum_q     <= sum_d;
      if (take) taps_q[tap_cnt_q] <= coef_in;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    bank_d     = bank_q;
    tap_cnt_d  = tap_cnt_q;
    step_d     = step_q;
    sum_d      = sum_q;
    take       = 1'b0;
    coef_ready = 1'b0;
    CLOAD      = 1'b0;
    CADDR      = '0;
    CIN        = '0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_COLLECT;
          bank_d    = '0;
          tap_cnt_d = '0;
        end
      end

      S_COLLECT: begin
        busy       = 1'b1;
        coef_ready = 1'b1;
        take       = coef_valid;
        if (coef_valid) begin
          tap_cnt_d = tap_cnt_q + 3'd1;
          if (tap_cnt_q == 3'd7) begin
            state_d = S_GEN;
            step_d  = '0;
            sum_d   = '0;
          end
        end
      end

      S_GEN: begin
        busy  = 1'b1;
        CLOAD = 1'b1;
        CADDR = {bank_q, gray_q};
        CIN   = sum_q;
        if (step_q == 8'hFF) begin
          tap_cnt_d = '0;
          if (bank_q == LAST_BANK) begin
            state_d = S_DONE;
            bank_d  = '0;
          end else begin
            state_d = S_COLLECT;
            bank_d  = bank_q + 3'd1;
          end
        end else begin
          step_d = step_nxt;
          sum_d  = gray_nxt[flip_bit] ? (sum_q + flip_ext) : (sum_q - flip_ext);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_da_lut_loader.sv
// Directed bench for da_lut_loader: captures every SRAM write, checks Gray order,
// timing and contents against a direct bit-sum reference of the LUT.
module tb_da_lut_loader;

  localparam int COEF_W = 16;

  logic              clk;
  logic              resetn;
  logic              start;
  logic [COEF_W-1:0] coef_in;
  logic              coef_valid;
  logic              coef_ready;
  logic [19:0]       CIN;
  logic [10:0]       CADDR;
  logic              CLOAD;
  logic              busy;
  logic              done;

  da_lut_loader #(.COEF_W(COEF_W), .NBANK(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .CIN        (CIN),
    .CADDR      (CADDR),
    .CLOAD      (CLOAD),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          load_id;
    logic [10:0] addr;
    logic [19:0] cin;
  } vec_t;

  vec_t        vecs[12];
  int          n_total = 0;
  int          n_bad   = 0;
  int          cur_taps[64];
  logic [19:0] mem[2048];
  logic [19:0] ref_copy[2048];
  int          hits[2048];
  int          wr_cnt, order_err, gap_err, done_cnt;
  int          first_wr, last_wr, done_cyc, start_cyc;
  bit          got_done, aborted;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [19:0] ref_lut(input int b, input int a);
    int s = 0;
    for (int i = 0; i < 8; i++) if (((a >> i) & 1) == 1) s += cur_taps[8*b + i];
    return 20'(s);
  endfunction

  task automatic clear_capture();
    for (int i = 0; i < 2048; i++) begin
      mem[i]  = 'x;
      hits[i] = 0;
    end
    wr_cnt = 0; order_err = 0; gap_err = 0; done_cnt = 0;
    first_wr = -1; last_wr = -1; done_cyc = -1;
  endtask

  // Called once per negedge while a load runs; records writes and protocol errors.
  task automatic sample_outputs();
    logic [10:0] w;
    logic [10:0] ea;
    if (CLOAD) begin
      w  = 11'(wr_cnt);
      ea = {w[10:8], w[7:0] ^ {1'b0, w[7:1]}};
      if (CADDR !== ea) order_err++;
      if (coef_ready) order_err++;
      mem[CADDR] = CIN;
      hits[CADDR]++;
      if (wr_cnt == 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy || CLOAD) order_err++;
    end
  endtask

  // mode 0: coef_valid held high; mode 1: coef_valid pattern 1,0,0 repeating.
  task automatic run_load(input int mode, input int busy_start_at, input bit do_abort);
    int idx;
    idx = 0; got_done = 0; aborted = 0;
    clear_capture();
    @(negedge clk);
    sample_outputs();
    start      = 1'b1;
    start_cyc  = cyc;
    coef_valid = (mode == 0);
    coef_in    = cur_taps[0][COEF_W-1:0];
    for (int t = 0; t < 6000; t++) begin
      @(negedge clk);
      sample_outputs();
      start = (t == busy_start_at);
      if (do_abort && CLOAD && CADDR == 11'h356) begin
        resetn  = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (done) begin
        got_done   = 1'b1;
        start      = 1'b1;
        coef_valid = 1'b0;
        break;
      end
      if (mode == 1 && idx < 64 && (idx % 8) != 0 && !coef_ready) gap_err++;
      coef_valid = (idx < 64) && (mode == 0 || (t % 3) == 0);
      if (idx < 64) coef_in = cur_taps[idx][COEF_W-1:0];
      else          coef_in = '0;
      if (coef_valid && coef_ready) idx++;
    end
    if (!do_abort) begin
      check("done_within_budget", got_done, 1);
      @(negedge clk); sample_outputs(); start = 1'b0;
      @(negedge clk); sample_outputs();
      check("start_with_done_ignored_busy", busy, 0);
      check("taps_consumed", idx, 64);
    end
  endtask

  task automatic verify_load(input string tag, input bit timing);
    int model_err = 0;
    int dup_err   = 0;
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 256; a++)
        if (mem[b*256 + a] !== ref_lut(b, a)) model_err++;
    for (int i = 0; i < 2048; i++) if (hits[i] != 1) dup_err++;
    check({tag, ":write_count"}, wr_cnt, 2048);
    check({tag, ":gray_order_errors"}, order_err, 0);
    check({tag, ":addr_not_once"}, dup_err, 0);
    check({tag, ":lut_errors"}, model_err, 0);
    check({tag, ":done_pulses"}, done_cnt, 1);
    check({tag, ":done_after_last_write"}, done_cyc - last_wr, 1);
    if (timing) begin
      check({tag, ":first_write_latency"}, first_wr - start_cyc, 9);
      check({tag, ":done_latency"}, done_cyc - start_cyc, 2113);
    end
  endtask

  task automatic check_vectors(input int load_id);
    for (int i = 0; i < 12; i++)
      if (vecs[i].load_id == load_id)
        check($sformatf("vec%0d_caddr_%03h", i, vecs[i].addr), mem[vecs[i].addr], vecs[i].cin);
  endtask

  initial begin
    vecs[0]  = '{0, 11'h0FF, 20'h000FF};
    vecs[1]  = '{0, 11'h055, 20'h00055};
    vecs[2]  = '{0, 11'h180, 20'h00000};
    vecs[3]  = '{0, 11'h780, 20'h00000};
    vecs[4]  = '{1, 11'h3FF, 20'h00008};
    vecs[5]  = '{1, 11'h055, 20'h00004};
    vecs[6]  = '{1, 11'h700, 20'h00000};
    vecs[7]  = '{1, 11'h001, 20'h00001};
    vecs[8]  = '{2, 11'h0FF, 20'hC0000};
    vecs[9]  = '{2, 11'h001, 20'hF8000};
    vecs[10] = '{2, 11'h7FF, 20'hC0000};
    vecs[11] = '{2, 11'h003, 20'hF0000};

    resetn = 1'b0; start = 1'b0; coef_valid = 1'b0; coef_in = '0;
    repeat (3) @(negedge clk);
    check("reset_CLOAD", CLOAD, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_coef_ready", coef_ready, 0);
    check("reset_CIN", CIN, 0);
    check("reset_CADDR", CADDR, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Identity: bank 0 taps are powers of two, a start pulse while busy is ignored.
    for (int k = 0; k < 64; k++) cur_taps[k] = (k < 8) ? (1 << k) : 0;
    run_load(0, 300, 1'b0);
    verify_load("identity", 1'b1);
    check_vectors(0);

    for (int k = 0; k < 64; k++) cur_taps[k] = 1;
    run_load(0, -1, 1'b0);
    verify_load("popcount", 1'b1);
    check_vectors(1);

    for (int k = 0; k < 64; k++) cur_taps[k] = -32768;
    run_load(0, -1, 1'b0);
    verify_load("neg_extreme", 1'b1);
    check_vectors(2);

    for (int k = 0; k < 64; k++) cur_taps[k] = int'($urandom_range(0, 65535)) - 32768;
    run_load(0, -1, 1'b0);
    verify_load("random", 1'b1);
    for (int i = 0; i < 2048; i++) ref_copy[i] = mem[i];

    begin
      int diff = 0;
      run_load(1, -1, 1'b0);
      verify_load("random_stall", 1'b0);
      for (int i = 0; i < 2048; i++) if (mem[i] !== ref_copy[i]) diff++;
      check("stall_vs_continuous_diff", diff, 0);
      check("stall_ready_dropped_in_gap", gap_err, 0);
    end

    // Mid-load reset at bank 3 step 100, then a fresh load from bank 0.
    for (int k = 0; k < 64; k++) cur_taps[k] = (k < 8) ? (1 << k) : 0;
    run_load(0, -1, 1'b1);
    check("abort_reached", aborted, 1);
    check("abort_writes_before_reset", wr_cnt, 3*256 + 101);
    @(negedge clk);
    check("abort_CLOAD", CLOAD, 0);
    check("abort_busy", busy, 0);
    check("abort_coef_ready", coef_ready, 0);
    check("abort_CADDR", CADDR, 0);
    resetn = 1'b1; coef_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 64; k++) cur_taps[k] = (k * 37 % 200) - 100;
    run_load(0, -1, 1'b0);
    verify_load("rearm", 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/da_lut_loader.md
Name: da_lut_loader

Overview:
- Coefficient pre-computation and loader for the distributed-arithmetic FIR core. It sits on the write side of the 8-bank coefficient SRAM and drives the core's CIN/CADDR/CLOAD port.
- It accepts 64 raw signed FIR taps, streamed bank by bank.
- For each bank it computes all 256 partial sums of that bank's 8 taps and writes them into the SRAM.
- It removes the need for host-side LUT generation.

Parameters:
- COEF_W, 16, signed coefficient width. Legal range 2..17, so that the sum of 8 taps fits in 20 bits.
- NBANK, 8, number of SRAM banks. Fixed at 8 to match the CADDR[10:8] bank field.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins a full 64-tap load; ignored unless IDLE
- coef_in  in  COEF_W  signed tap value
- coef_valid  in  1  coef_in valid
- coef_ready  out  1  loader accepts coef_in this cycle
- CIN  out  20  partial-sum data to SRAM, two's complement
- CADDR  out  11  {bank[2:0], lut_addr[7:0]}
- CLOAD  out  1  write strobe; CIN/CADDR valid when high
- busy  out  1  load sequence in progress
- done  out  1  one-cycle pulse after the final write of bank 7

Behaviour:
- Reset values: all outputs 0. State IDLE, bank counter 0, tap buffer cleared, running sum 0.
- Tap mapping: the k-th accepted coefficient (k = 0..63) is tap h[k]. It belongs to bank k/8 and drives address bit k%8 of that bank.
- LUT content: LUT_b[a] = sum over set bits i of a of h[8b+i]. The result is sign-extended to 20 bits. No saturation is needed because the width bound guarantees no overflow.
- IDLE:
  - coef_ready=0, CLOAD=0, busy=0.
  - On start, go to COLLECT and set busy=1 from the next cycle.
- COLLECT:
  - coef_ready=1.
  - Each cycle with coef_valid&coef_ready stores coef_in into buffer slot tap_cnt, then increments tap_cnt (0..7).
  - Gaps in coef_valid stall without penalty.
  - coef_ready drops the cycle after the 8th acceptance.
  - On the 8th acceptance, go to GEN with step k=0 and sum=0.
- GEN (256 consecutive cycles, no stalls):
  - In step k, CLOAD=1, CADDR={bank, g(k)} where g(k)=k^(k>>1) (Gray order), and CIN=sum for g(k).
  - Step 0 writes address 0 with CIN=0.
  - Moving from step k to k+1, exactly one bit j changes. j is the index of the lowest set bit of k+1.
  - If g(k+1)[j] becomes 1, then sum += h[j]; otherwise sum -= h[j].
  - The sum register is 20 bits, and every h is sign-extended to 20 bits before the add.
  - First write occurs the cycle after the 8th coefficient is accepted.
  - The address sequence is 00,01,03,02,06,07,05,04,...,80 (last = g(255)=0x80).
- Bank advance (after step 255):
  - If bank<7: bank++, tap_cnt=0, return to COLLECT. CLOAD is low in the following cycle.
  - If bank==7: in the next cycle done=1 for one cycle, busy=0, CLOAD=0, state returns to IDLE, bank resets to 0.
- Total CLOAD-high cycles per load: 2048, each CADDR value written exactly once.
- start while busy is ignored, and a start in the same cycle as done is also ignored.
- coef_valid outside COLLECT is ignored; coef_in is not consumed.
- resetn low mid-sequence: at the next edge the block returns to IDLE with all outputs 0, including CLOAD dropping immediately. A partially written LUT is left as-is; a fresh start restarts from bank 0.
- Latency from start to first CLOAD, with coef_valid held high: start at cycle 0, COLLECT from cycle 1, accepts at cycles 1..8, first write at cycle 9.
- Full-load latency with continuous coef_valid: 8 × (8 + 256) cycles to the last write, plus 1 cycle to done.

Test Plan:
- Identity: bank 0 taps = 1,2,4,...,128; other banks 0 -> bank 0 LUT[a]=a for all a; banks 1..7 all 0; CADDR sequence is Gray order; exactly 2048 CLOAD cycles; done pulse 1 cycle after the final write to CADDR 0x780.
- Popcount: all 64 taps = 1 -> every bank LUT[a]=popcount(a); e.g. CADDR 0x3FF -> CIN=8, CADDR 0x055 -> CIN=4.
- Negative extreme: all taps = -32768 -> LUT[0xFF] = -262144 = 20'hC0000; LUT[0x01] = 20'hF8000; all upper bits correctly sign-extended.
- Handshake stall: coef_valid toggled 1,0,0,1,... during COLLECT -> only valid&ready cycles are consumed; coef_ready stays 1 across gaps; LUT contents identical to the continuous-stream result.
- Mid-load reset and re-arm: assert resetn=0 at bank 3 step 100 -> CLOAD=0, busy=0, coef_ready=0 next cycle. Then start -> sequence restarts at bank 0 and completes with correct contents. A start pulse issued while busy has no effect.
- Random taps: 64 random signed COEF_W values -> scoreboard reference-model check of all 2048 (CADDR, CIN) pairs.
